// File: rtl/coin_keypad_encoder.sv
// Front-panel encoder: synchronises and debounces buttons, then paces legal commands onto in_code.
// Press-to-code latency DB_CYCLES+4; while busy (hold, gap, change payout) presses wait as pending bits.
module coin_keypad_encoder #(
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 2,
  parameter int CHG_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       a_reset,
  input  logic       btn_coin1,
  input  logic       btn_coin5,
  input  logic       btn_vend,
  input  logic       btn_change,
  input  logic       btn_clear,
  input  logic [3:0] sum,
  input  logic [4:0] can_buy,
  output logic [2:0] in_code,
  output logic       busy,
  output logic       reject,
  output logic [2:0] reject_code,
  output logic       chg_err
);

  localparam logic [2:0] C_NONE   = 3'b000;
  localparam logic [2:0] C_COIN1  = 3'b001;
  localparam logic [2:0] C_COIN5  = 3'b010;
  localparam logic [2:0] C_VEND   = 3'b101;
  localparam logic [2:0] C_CHANGE = 3'b110;
  localparam logic [2:0] C_CLEAR  = 3'b111;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(CHG_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, WAIT_CHG} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       btn_raw, sync1, sync2, db, db_q, rise, pend;
  logic [CNT_W-1:0] db_cnt [5];
  logic [4:0]       sel_mask;
  logic [2:0]       sel_code;
  logic             sel_ok, idle_take, take_clear;
  logic             unused_can_buy;

  // Bit order doubles as priority: bit 4 (clear) wins.
  assign btn_raw        = {btn_clear, btn_change, btn_vend, btn_coin5, btn_coin1};
  assign rise           = db & ~db_q;
  assign unused_can_buy = ^can_buy[4:1];

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_q  <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      db_q  <= db;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_mask = '0;
    sel_code = C_NONE;
    sel_ok   = 1'b0;
    if (pend[4]) begin
      sel_mask = 5'b10000; sel_code = C_CLEAR;  sel_ok = 1'b1;
    end else if (pend[3]) begin
      sel_mask = 5'b01000; sel_code = C_CHANGE; sel_ok = (sum != 4'd0);
    end else if (pend[2]) begin
      sel_mask = 5'b00100; sel_code = C_VEND;   sel_ok = can_buy[0];
    end else if (pend[1]) begin
      sel_mask = 5'b00010; sel_code = C_COIN5;  sel_ok = (sum <= 4'd5);
    end else if (pend[0]) begin
      sel_mask = 5'b00001; sel_code = C_COIN1;  sel_ok = (sum <= 4'd9);
    end
  end

  assign idle_take  = (state == IDLE) && (sel_mask != 5'b00000);
  assign take_clear = idle_take && sel_mask[4];

  // New edges are OR'd in after clearing so a fresh press is never lost.
  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset)         pend <= '0;
    else if (take_clear) pend <= rise;
    else if (idle_take)  pend <= (pend & ~sel_mask) | rise;
    else                 pend <= pend | rise;
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      in_code     <= C_NONE;
      busy        <= 1'b0;
      reject      <= 1'b0;
      reject_code <= C_NONE;
      chg_err     <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_take) begin
            if (sel_ok) begin
              in_code <= sel_code;
              busy    <= 1'b1;
              cnt     <= '0;
              state   <= ISSUE;
              if (sel_mask[4]) chg_err <= 1'b0;
            end else begin
              reject      <= 1'b1;
              reject_code <= sel_code;
            end
          end
        end
        ISSUE: begin
          if (cnt == HOLD_LAST) begin
            in_code <= C_NONE;
            cnt     <= '0;
            state   <= (in_code == C_CHANGE) ? WAIT_CHG : GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_CHG: begin
          // Pending clear abandons the payout wait; IDLE issues it next cycle.
          if (pend[4]) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (sum == 4'd0) begin
            cnt   <= '0;
            state <= GAP;
          end else if (cnt == TO_LAST) begin
            cnt     <= '0;
            chg_err <= 1'b1;
            state   <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          in_code <= C_NONE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_keypad_encoder.sv
// Bench for coin_keypad_encoder: directed timing checks plus random multi-press trials
// compared against an event-sequence model built from the priority and eligibility rules.
module tb_coin_keypad_encoder;
  localparam int DB   = 4;
  localparam int HOLD = 1;
  localparam int GAP  = 2;
  localparam int TO   = 64;

  logic       clk = 1'b0;
  logic       a_reset = 1'b1;
  logic       btn_coin1 = 1'b0, btn_coin5 = 1'b0, btn_vend = 1'b0, btn_change = 1'b0, btn_clear = 1'b0;
  logic [3:0] sum = 4'd0;
  logic [4:0] can_buy = 5'd0;
  logic [2:0] in_code, reject_code;
  logic       busy, reject, chg_err;

  always #5 clk = ~clk;

  coin_keypad_encoder #(
    .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CHG_TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk(clk), .a_reset(a_reset),
    .btn_coin1(btn_coin1), .btn_coin5(btn_coin5), .btn_vend(btn_vend),
    .btn_change(btn_change), .btn_clear(btn_clear),
    .sum(sum), .can_buy(can_buy),
    .in_code(in_code), .busy(busy), .reject(reject),
    .reject_code(reject_code), .chg_err(chg_err)
  );

  // Observed events: issued code (1..7) or reject (8 + code), with cycle stamp.
  typedef struct {int code; int cyc;} evt_t;
  evt_t       obs_q[$];
  int         exp_q[$];
  int         mon_cyc = 0;
  logic [2:0] prev_code = 3'b000;
  int         n_cmp = 0, n_bad = 0;

  always @(negedge clk) begin
    mon_cyc++;
    if (!a_reset) begin
      if (in_code != 3'b000 && prev_code == 3'b000) obs_q.push_back('{int'(in_code), mon_cyc});
      if (reject) obs_q.push_back('{8 + int'(reject_code), mon_cyc});
      prev_code = in_code;
    end else begin
      prev_code = 3'b000;
    end
  end

  task automatic check_eq(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic check_events(input string tag);
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check_eq($sformatf("%s_evt%0d", tag, i), (i < obs_q.size()) ? obs_q[i].code : -1, exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  task automatic set_btns(input logic [4:0] m);
    {btn_clear, btn_change, btn_vend, btn_coin5, btn_coin1} = m;
  endtask

  task automatic wait_code(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (in_code != 3'b000) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int lat, hold, bcnt, n, busy_all, sp;
    logic [4:0] m;
    int nb;

    tickn(3);
    check_eq("rst_in_code", int'(in_code), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_reject", int'(reject), 0);
    check_eq("rst_reject_code", int'(reject_code), 0);
    check_eq("rst_chg_err", int'(chg_err), 0);
    a_reset = 1'b0;
    tickn(2);
    obs_q.delete();

    // Clean coin1 press: exact latency, hold width and busy width.
    sum = 4'd0;
    set_btns(5'b00001);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (in_code != 3'b000) begin lat = i; break; end
    end
    check_eq("t2_latency", lat, DB + 4);
    check_eq("t2_code", int'(in_code), 1);
    hold = 0; bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_code == 3'b001) hold++;
      if (busy) bcnt++;
      if (i == 2) set_btns(5'b00000);
      tick();
    end
    check_eq("t2_hold", hold, HOLD);
    check_eq("t2_busy", bcnt, HOLD + GAP);
    tickn(10);
    exp_q = '{1};
    check_events("t2");

    // Short glitches on coin5 never become a press.
    for (int r = 0; r < 2; r++)
      for (int len = 1; len < DB; len++) begin
        set_btns(5'b00010); tickn(len);
        set_btns(5'b00000); tickn(8);
      end
    tickn(10);
    check_events("t3_glitch");

    // Ineligible vend, then ineligible coin5.
    can_buy = 5'b00000;
    set_btns(5'b00100); tickn(DB + 4); set_btns(5'b00000); tickn(15);
    exp_q = '{8 + 5};
    check_events("t4_vend");
    check_eq("t4_rcode_vend", int'(reject_code), 5);
    sum = 4'd6;
    set_btns(5'b00010); tickn(DB + 4); set_btns(5'b00000); tickn(15);
    exp_q = '{8 + 2};
    check_events("t4_coin5");
    check_eq("t4_rcode_hold", int'(reject_code), 2);

    // Simultaneous coin1+coin5: coin5 first, then coin1 after the gap and one idle cycle.
    sum = 4'd0;
    set_btns(5'b00011); tickn(DB + 4); set_btns(5'b00000); tickn(25);
    sp = (obs_q.size() >= 2) ? obs_q[1].cyc - obs_q[0].cyc : -1;
    check_eq("t5_spacing", sp, HOLD + GAP + 1);
    exp_q = '{2, 1};
    check_events("t5");

    // Change paid out normally after 10 cycles.
    sum = 4'd3;
    set_btns(5'b01000);
    wait_code(40);
    check_eq("t6_issue", int'(in_code), 6);
    set_btns(5'b00000);
    busy_all = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!busy) busy_all = 0;
    end
    check_eq("t6_busy_wait", busy_all, 1);
    sum = 4'd0;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (!busy) break;
      tick();
      n++;
    end
    check_eq("t6_tail", n, GAP + 1);
    check_eq("t6_chg_err", int'(chg_err), 0);
    exp_q = '{6};
    check_events("t6");

    // Change with sum stuck: timeout sets chg_err.
    sum = 4'd3;
    set_btns(5'b01000);
    wait_code(40);
    check_eq("t6b_issue", int'(in_code), 6);
    set_btns(5'b00000);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (chg_err) begin n = i; break; end
    end
    check_eq("t6b_timeout", n, HOLD + TO);
    tickn(GAP + 2);
    check_eq("t6b_idle", int'(busy), 0);
    exp_q = '{6};
    check_events("t6b");

    // Stuck change, then clear (with coin1): clear preempts and wipes coin1.
    set_btns(5'b01000);
    wait_code(40);
    check_eq("t7_issue", int'(in_code), 6);
    set_btns(5'b00000);
    tickn(8);
    check_eq("t7_sticky", int'(chg_err), 1);
    set_btns(5'b10001);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (in_code == 3'b111) break;
    end
    check_eq("t7_clear", int'(in_code), 7);
    hold = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_code == 3'b111) hold++;
      if (i == 0) set_btns(5'b00000);
      tick();
    end
    check_eq("t7_hold", hold, HOLD);
    check_eq("t7_chg_err", int'(chg_err), 0);
    sum = 4'd0;
    tickn(20);
    exp_q = '{6, 7};
    check_events("t7");

    // Async reset mid-ISSUE; button held through reset gives exactly one press.
    set_btns(5'b00001);
    wait_code(40);
    check_eq("t8_issue", int'(in_code), 1);
    #2 a_reset = 1'b1;
    #1;
    check_eq("t8_async_code", int'(in_code), 0);
    check_eq("t8_async_busy", int'(busy), 0);
    tickn(3);
    a_reset = 1'b0;
    obs_q.delete();
    tickn(DB + 15);
    set_btns(5'b00000);
    tickn(10);
    exp_q = '{1};
    check_events("t8_held");

    // Random multi-press trials with bounce.
    for (int t = 0; t < 20; t++) begin
      sum = 4'($urandom_range(0, 10));
      can_buy = 5'($urandom);
      m = {2'b00, 3'($urandom_range(1, 7))};
      nb = $urandom_range(0, 2);
      for (int b = 0; b < nb; b++) begin
        set_btns(m); tickn($urandom_range(1, DB - 1));
        set_btns(5'b00000); tickn($urandom_range(1, 3));
      end
      set_btns(m); tickn(DB + 2 + $urandom_range(0, 4));
      set_btns(5'b00000); tickn(40);
      if (m[2]) exp_q.push_back(can_buy[0] ? 5 : 8 + 5);
      if (m[1]) exp_q.push_back((sum <= 4'd5) ? 2 : 8 + 2);
      if (m[0]) exp_q.push_back((sum <= 4'd9) ? 1 : 8 + 1);
      check_events($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
